canny_window3x3: RTL and testbench
==================================

Name: canny_window3x3

Overview:
First stage inside the Canny pipeline, directly downstream of the raster pixel stream (clk, rstN, pixel_in, pixel_in_valid). It buffers two image rows and emits a 3x3 neighbourhood window for every interior pixel. The window feeds the Gaussian/Sobel kernels. The stream has no backpressure: input is accepted whenever valid is high, and output is a valid-qualified registered window.

Parameters:
PIX_W, 8, pixel width in bits
IMG_W, 512, pixels per row (>=3)
IMG_H, 512, rows per frame (>=3)

Ports:
clk  in  1  system clock, rising edge
rstN  in  1  asynchronous active-low reset
pixel_in  in  PIX_W  raster-order pixel, row-major, frame start at (0,0)
pixel_in_valid  in  1  pixel_in is accepted this cycle
window_out  out  9*PIX_W  3x3 window; element k at [k*PIX_W +: PIX_W], k=row*3+col, k=0 top-left, k=8 bottom-right
window_valid  out  1  window_out holds a new window this cycle
frame_done  out  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset (async assert, sync release): window_out=0, window_valid=0, frame_done=0, col=0, row=0, state=ST_FILL. Line buffer contents are not cleared; ST_FILL guarantees they are rewritten before use.
- Accept rule: a pixel is consumed only on a rising edge with pixel_in_valid=1. With pixel_in_valid=0, all counters, shift registers and buffers hold, window_valid=0 and frame_done=0.
- Counters: col counts 0..IMG_W-1 and wraps to 0 while incrementing row. row counts 0..IMG_H-1 and wraps to 0 at frame end. There is no gap between frames.
- Line buffers: two IMG_W-deep delays in cascade. Tap0 is the current pixel, tap1 is the same column one row earlier, and tap2 is the same column two rows earlier.
- Column shift: each of the three rows has a 3-deep shift register, advanced on accept.
- Output rule: when pixel (r,c) is accepted with r>=2 and c>=2, the next cycle has window_valid=1 and a window centred on (r-1,c-1):
  - k0..2 = row r-2, cols c-2..c
  - k3..5 = row r-1, cols c-2..c
  - k6..8 = row r, cols c-2..c
- Latency: 1 cycle from the accepting edge to window_valid.
- Border pixels get no window. This gives (IMG_H-2)*(IMG_W-2) windows per frame.
- Windows never straddle rows or frames. Columns 0-1 of every row are suppressed, and so are rows 0-1 of every frame.
- window_out holds its last value when window_valid=0.
- FSM:
  - ST_FILL: rows 0..1 are being received. Go to ST_RUN on accepting (1,IMG_W-1).
  - ST_RUN: windows are emitted. On accepting (IMG_H-1,IMG_W-1), go to ST_FILL and assert frame_done in the same output cycle as the final window.
- Simultaneous events: frame_done and window_valid are both 1 on the last window. The first pixel of the next frame may be accepted in the very next cycle.
- Reset mid-frame: outputs drop to 0 immediately (async). The next accepted pixel is treated as (0,0).
- Arithmetic: no pixel arithmetic. Counter widths are $clog2(IMG_W) and $clog2(IMG_H).

Decomposition:
- Package canny_pkg holds:
  - PIX_W_DEF, IMG_W_DEF, IMG_H_DEF
  - window index constants WIN_TL..WIN_BR (0..8)
  - typedef state_e {ST_FILL, ST_RUN}
  - typedef pixel_t = logic [PIX_W-1:0]
- Sub-module canny_line_buffer: an IMG_W-deep, PIX_W-wide delay line. It uses a circular RAM with a write/read pointer advanced on enable. Two instances are cascaded.

Test Plan:
Benches use IMG_W=IMG_H=5 and pixel value = r*5+c unless stated.
1. Reset then a full frame with continuous valid -> the first window_valid comes one cycle after accepting index 12, with window {0,1,2,5,6,7,10,11,12}. Exactly 9 windows are produced.
2. Same frame -> the last window is {12,13,14,17,18,19,22,23,24}, with frame_done=1 in the same cycle. frame_done pulses exactly once.
3. Insert 3-cycle valid gaps after index 7 and index 17 -> the window sequence is identical to scenario 1, and window_valid=0 during the gaps.
4. Two back-to-back frames, with frame 2 values +100 -> no window is produced for frame 2 indices 0..11. Frame 2's first window is {100,101,102,105,106,107,110,111,112}.
5. Drive rstN low for 2 cycles after 8 accepted pixels, then a fresh frame -> outputs are 0 during reset. The fresh frame's windows match scenario 1 exactly.
6. Default params with the 512x512 t111 image -> exactly 260100 windows and one frame_done. A reference 3x3 model check passes.

Source files
------------

// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared constants and types for the 3x3 window stage
package canny_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int IMG_W_DEF = 512;
    localparam int IMG_H_DEF = 512;

    // Window element positions, k = row*3 + col, row 0 is the oldest image row
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/canny_window3x3_if.sv
// rtl/canny_window3x3_if.sv - pixel stream in, 3x3 window stream out
interface canny_window3x3_if import canny_pkg::*; #(
    parameter int PIX_W = PIX_W_DEF
) ();

    logic [PIX_W-1:0]   pixel_in;
    logic               pixel_in_valid;
    logic [9*PIX_W-1:0] window_out;
    logic               window_valid;
    logic               frame_done;

    modport master (
        output pixel_in, pixel_in_valid,
        input  window_out, window_valid, frame_done
    );

    modport slave (
        input  pixel_in, pixel_in_valid,
        output window_out, window_valid, frame_done
    );

endinterface

// File: rtl/canny_line_buffer.sv
// rtl/canny_line_buffer.sv - DEPTH-deep pixel delay line on a circular RAM
module canny_line_buffer import canny_pkg::*; #(
    parameter int PIX_W = PIX_W_DEF,
    parameter int DEPTH = IMG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    // The slot about to be overwritten holds the pixel from DEPTH accepts ago
    assign dout = mem[ptr];

    // Single pointer serves as both read and write address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    // Storage needs no reset; the FILL phase rewrites it before any window uses it
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/canny_window3x3.sv
// rtl/canny_window3x3.sv - two-row buffer emitting a 3x3 window per interior pixel
module canny_window3x3 import canny_pkg::*; #(
    parameter int PIX_W = PIX_W_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    canny_window3x3_if.slave        bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic             accept;
    logic [PIX_W-1:0] tap0, tap1, tap2;
    // Per image row: [0] holds column c-1, [1] holds column c-2; tap is column c
    logic [PIX_W-1:0] top_sr [2];
    logic [PIX_W-1:0] mid_sr [2];
    logic [PIX_W-1:0] bot_sr [2];
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    state_e           state_q, state_d;
    logic             emit, last;
    logic [9*PIX_W-1:0] win_d;
    logic [9*PIX_W-1:0] window_q;
    logic             valid_q, done_q;

    assign accept = bus.pixel_in_valid;
    assign tap0   = bus.pixel_in;

    canny_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb0 (
        .clk(clk), .rst_n(rst_n), .en(accept), .din(tap0), .dout(tap1)
    );

    canny_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .rst_n(rst_n), .en(accept), .din(tap1), .dout(tap2)
    );

    // Column history for each of the three rows, advanced on every accepted pixel
    always_ff @(posedge clk) begin
        if (accept) begin
            top_sr[1] <= top_sr[0];
            top_sr[0] <= tap2;
            mid_sr[1] <= mid_sr[0];
            mid_sr[0] <= tap1;
            bot_sr[1] <= bot_sr[0];
            bot_sr[0] <= tap0;
        end
    end

    // Raster position of the pixel being offered this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Phase register: FILL while the first two rows load, RUN while windows flow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next phase, window emit and end-of-frame decisions for this accept
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (accept && row == RW'(1) && col == COL_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    emit = (col >= CW'(2));
                    if (row == ROW_LAST && col == COL_LAST) begin
                        last    = 1'b1;
                        state_d = ST_FILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Assemble the window centred one row up and one column left of the live pixel
    always_comb begin
        win_d = '0;
        win_d[WIN_TL*PIX_W +: PIX_W] = top_sr[1];
        win_d[WIN_TC*PIX_W +: PIX_W] = top_sr[0];
        win_d[WIN_TR*PIX_W +: PIX_W] = tap2;
        win_d[WIN_ML*PIX_W +: PIX_W] = mid_sr[1];
        win_d[WIN_MC*PIX_W +: PIX_W] = mid_sr[0];
        win_d[WIN_MR*PIX_W +: PIX_W] = tap1;
        win_d[WIN_BL*PIX_W +: PIX_W] = bot_sr[1];
        win_d[WIN_BC*PIX_W +: PIX_W] = bot_sr[0];
        win_d[WIN_BR*PIX_W +: PIX_W] = tap0;
    end

    // Registered outputs; the window holds its value between valid cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= emit;
            done_q  <= last;
            if (emit) begin
                window_q <= win_d;
            end
        end
    end

    assign bus.window_out   = window_q;
    assign bus.window_valid = valid_q;
    assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_canny_window3x3.sv
// tb/tb_canny_window3x3.sv - randomized bench against a frame-array window model
module tb_canny_window3x3;
    import canny_pkg::*;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    canny_window3x3_if #(.PIX_W(PW)) bus ();

    canny_window3x3 #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          img [H][W];
    int          mr = 0;
    int          mc = 0;
    logic [71:0] last_win = '0;
    int          win_cnt = 0;
    int          done_cnt = 0;
    logic [71:0] first_win = '0;
    bit          first_seen = 0;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window of a ramp image (value = r*5+c + base) whose top-left value is tl
    function automatic logic [71:0] ramp_win(input int tl);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*8 +: 8] = 8'(tl + i*W + j);
        return w;
    endfunction

    task automatic clear_stats();
        win_cnt = 0;
        done_cnt = 0;
        first_seen = 0;
        first_win = '0;
    endtask

    // Offer one pixel for one cycle, update the model, then check the outputs
    task automatic step(input bit v, input int pix);
        logic [71:0] exp_win;
        bit exp_valid, exp_done;
        bus.pixel_in = 8'(pix);
        bus.pixel_in_valid = v;
        @(posedge clk);
        #1;
        exp_valid = 0;
        exp_done = 0;
        exp_win = last_win;
        if (v) begin
            img[mr][mc] = pix & 8'hff;
            if (mr >= 2 && mc >= 2) begin
                exp_valid = 1;
                exp_done = (mr == H-1 && mc == W-1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_win[(i*3+j)*8 +: 8] = 8'(img[mr-2+i][mc-2+j]);
            end
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
        check_eq("window_valid", 72'(bus.window_valid), 72'(exp_valid));
        check_eq("frame_done", 72'(bus.frame_done), 72'(exp_done));
        check_eq(exp_valid ? "window_out" : "window_hold", bus.window_out, exp_win);
        last_win = exp_win;
        if (bus.window_valid) begin
            win_cnt++;
            if (!first_seen) begin
                first_seen = 1;
                first_win = bus.window_out;
            end
        end
        if (bus.frame_done) done_cnt++;
        bus.pixel_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 72'(bus.window_valid), 72'(0));
        check_eq("rst_done", 72'(bus.frame_done), 72'(0));
        check_eq("rst_window", bus.window_out, 72'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mr = 0;
        mc = 0;
        last_win = '0;
    endtask

    // One full ramp frame; gaps of 3 idle cycles after indices 7 and 17 if requested
    task automatic ramp_frame(input int base, input bit gaps);
        for (int idx = 0; idx < W*H; idx++) begin
            step(1, base + idx);
            if (gaps && (idx == 7 || idx == 17))
                repeat (3) step(0, $urandom);
        end
    endtask

    task automatic check_frame(input string tag, input int base);
        check_eq({tag, "_first"}, first_win, ramp_win(base));
        check_eq({tag, "_count"}, 72'(win_cnt), 72'((H-2)*(W-2)));
        check_eq({tag, "_done_cnt"}, 72'(done_cnt), 72'(1));
        check_eq({tag, "_last"}, bus.window_out, ramp_win(base + 12));
    endtask

    initial begin
        bus.pixel_in = '0;
        bus.pixel_in_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        clear_stats();
        ramp_frame(0, 0);
        check_frame("s1", 0);

        clear_stats();
        ramp_frame(0, 1);
        check_frame("s3", 0);

        clear_stats();
        ramp_frame(0, 0);
        clear_stats();
        for (int idx = 0; idx < 12; idx++) step(1, 100 + idx);
        check_eq("s4_no_early", 72'(win_cnt), 72'(0));
        for (int idx = 12; idx < W*H; idx++) step(1, 100 + idx);
        check_frame("s4", 100);

        for (int idx = 0; idx < 8; idx++) step(1, 200 + idx);
        do_reset();
        clear_stats();
        ramp_frame(0, 0);
        check_frame("s5", 0);

        for (int f = 0; f < 6; f++) begin
            int sent;
            clear_stats();
            sent = 0;
            while (sent < W*H) begin
                if ($urandom_range(0, 3) != 0) begin
                    step(1, $urandom);
                    sent++;
                end else begin
                    step(0, $urandom);
                end
            end
            check_eq("rnd_count", 72'(win_cnt), 72'((H-2)*(W-2)));
            check_eq("rnd_done_cnt", 72'(done_cnt), 72'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
